// File: rtl/rtcore_host_ctrl_pkg.sv
// rtcore_host_ctrl_pkg: shared ray/result datatype widths and host controller FSM states
// Provides `RAY_WIDTH / `RESULT_WIDTH (overridable on the command line) plus
// RAY_W / RES_W mirrors for code that prefers package constants, and host_state_t.
`ifndef RAY_WIDTH
`define RAY_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 24
`endif

package rtcore_host_ctrl_pkg;
   localparam int RAY_W = `RAY_WIDTH;
   localparam int RES_W = `RESULT_WIDTH;
   typedef enum logic [1:0] {IDLE, RUN, DONE} host_state_t;
endpackage

// File: rtl/rtcore_host_ctrl_fifo.sv
// host_ray_fifo: ray prefetch FIFO between the ray SRAM and the rtcore ray stream
// Ports: clk/arst_n clock and async active-low reset; clr synchronous flush;
// push/din write side; pop/dout show-ahead read side; full/empty/count status.
module host_ray_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign empty = count == '0;
   assign full  = count == CW'(DEPTH);
endmodule

// File: rtl/rtcore_host_ctrl.sv
// rtcore_host_ctrl: streams rays from SRAM into the rtcore and collects results into SRAM
// Ports: clk, arst_n (async active-low); start/num_rays job request; busy/done status;
// ray_sram_rd* ray SRAM read port (1-cycle latency); ray_stream_* producer side of
// the ray FIFO; result_stream_* show-ahead consumer side of the result FIFO;
// res_sram_wr* result SRAM write port.
module rtcore_host_ctrl
   import rtcore_host_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 16,
   parameter int BUF_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     start,
   input  logic [CNT_WIDTH-1:0]     num_rays,
   output logic                     busy,
   output logic                     done,
   output logic                     ray_sram_rd,
   output logic [CNT_WIDTH-1:0]     ray_sram_rd_addr,
   input  logic [`RAY_WIDTH-1:0]    ray_sram_rd_dout,
   input  logic                     ray_stream_full_n,
   output logic                     ray_stream_write,
   output logic [`RAY_WIDTH-1:0]    ray_stream_din,
   input  logic                     result_stream_empty_n,
   output logic                     result_stream_read,
   input  logic [`RESULT_WIDTH-1:0] result_stream_dout,
   output logic                     res_sram_wr,
   output logic [CNT_WIDTH-1:0]     res_sram_wr_addr,
   output logic [`RESULT_WIDTH-1:0] res_sram_wr_din
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;

   host_state_t          state, state_nx;
   logic [CNT_WIDTH-1:0] num_q, rd_ptr, col_cnt;
   logic                 rd_q, accept, fifo_full, fifo_empty;
   logic [CW-1:0]        fifo_cnt;
   logic [CW:0]          pending;

   assign accept = (state == IDLE) && start;
   assign busy   = state != IDLE;
   assign done   = state == DONE;

   // Slots already claimed: buffered rays plus the read in flight, minus the entry
   // leaving this cycle, so a full-rate stream keeps one read issued every cycle.
   assign pending = {1'b0, fifo_cnt} - {{CW{1'b0}}, ray_stream_write} + {{CW{1'b0}}, rd_q};

   assign ray_sram_rd      = (state == RUN) && (rd_ptr < num_q) && (!fifo_full || ray_stream_write)
                             && (pending < (CW+1)'(BUF_DEPTH));
   assign ray_sram_rd_addr = rd_ptr;
   assign ray_stream_write = !fifo_empty && ray_stream_full_n;

   assign result_stream_read = (state == RUN) && result_stream_empty_n && (col_cnt < num_q);
   assign res_sram_wr        = result_stream_read;
   assign res_sram_wr_addr   = col_cnt;
   assign res_sram_wr_din    = result_stream_dout;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE) ? (start ? RUN : IDLE)
               : (state == RUN)  ? ((col_cnt == num_q) ? DONE : RUN)
               : IDLE;
   end

   // rd_q marks the cycle the SRAM returns data; reset drops any read in flight
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         num_q   <= '0;
         rd_ptr  <= '0;
         col_cnt <= '0;
         rd_q    <= 1'b0;
      end else begin
         rd_q <= ray_sram_rd;
         if (accept) begin
            num_q   <= num_rays;
            rd_ptr  <= '0;
            col_cnt <= '0;
         end else begin
            if (ray_sram_rd) rd_ptr <= rd_ptr + CNT_WIDTH'(1);
            if (result_stream_read) col_cnt <= col_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // a new job flushes any rays left over from a job that finished early
   host_ray_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (`RAY_WIDTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .arst_n(arst_n),
      .clr   (accept),
      .push  (rd_q),
      .din   (ray_sram_rd_dout),
      .pop   (ray_stream_write),
      .dout  (ray_stream_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );
endmodule

// File: tb/tb_rtcore_host_ctrl.sv
// tb_rtcore_host_ctrl: directed bench with a cycle-level reference model for rtcore_host_ctrl
module tb_rtcore_host_ctrl;
   import rtcore_host_ctrl_pkg::*;

   localparam int CNTW  = 16;
   localparam int DEPTH = 2;

   logic            clk = 0, arst_n = 0, start = 0;
   logic [CNTW-1:0] num_rays = '0;
   logic            busy, done, ray_sram_rd, ray_stream_write, result_stream_read, res_sram_wr;
   logic [CNTW-1:0] ray_sram_rd_addr, res_sram_wr_addr;
   logic [RAY_W-1:0] ray_sram_rd_dout = '0, ray_stream_din;
   logic            ray_stream_full_n = 1'b1, result_stream_empty_n = 1'b0;
   logic [RES_W-1:0] result_stream_dout = '0, res_sram_wr_din;

   rtcore_host_ctrl #(.CNT_WIDTH(CNTW), .BUF_DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .arst_n               (arst_n),
      .start                (start),
      .num_rays             (num_rays),
      .busy                 (busy),
      .done                 (done),
      .ray_sram_rd          (ray_sram_rd),
      .ray_sram_rd_addr     (ray_sram_rd_addr),
      .ray_sram_rd_dout     (ray_sram_rd_dout),
      .ray_stream_full_n    (ray_stream_full_n),
      .ray_stream_write     (ray_stream_write),
      .ray_stream_din       (ray_stream_din),
      .result_stream_empty_n(result_stream_empty_n),
      .result_stream_read   (result_stream_read),
      .result_stream_dout   (result_stream_dout),
      .res_sram_wr          (res_sram_wr),
      .res_sram_wr_addr     (res_sram_wr_addr),
      .res_sram_wr_din      (res_sram_wr_din)
   );

   always #5 clk = ~clk;

   function automatic logic [RAY_W-1:0] ray_val(int a);
      return RAY_W'(32'h1000_0000 + a * 17 + 5);
   endfunction

   function automatic logic [RES_W-1:0] res_val(int id);
      return RES_W'(24'hC0_0000 + id * 257 + 3);
   endfunction

   typedef struct {int id; int ready;} res_t;
   res_t rq[$];

   int n_chk = 0, n_pass = 0, cyc = 0;

   task automatic chk(string name, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // environment: ray SRAM with 1-cycle latency, ray FIFO back-pressure, result FIFO
   int fmode = 0;
   bit lb = 0, pend = 0;
   int pend_addr = 0;
   always @(posedge clk) begin
      cyc++;
      #1;
      if (pend) ray_sram_rd_dout = ray_val(pend_addr);
      pend = 0;
      ray_stream_full_n = (fmode == 0) ? 1'b1 : cyc[0];
      if (rq.size() > 0) begin
         result_stream_empty_n = rq[0].ready <= cyc;
         result_stream_dout = res_val(rq[0].id);
      end else begin
         result_stream_empty_n = 1'b0;
         result_stream_dout = '0;
      end
   end

   // reference model: job phase, rays fetched/sent, results collected
   int m_state = 0, m_n = 0, m_col = 0, m_ray = 0, m_issued = 0;
   bit prev_rd = 0;
   int w_count = 0, w_first = -1, w_last = -1, r_count = 0, act = 0;
   logic [RES_W-1:0] res_mem [64];

   always @(negedge clk) begin
      bit ew, er, err;
      if (ray_sram_rd) begin pend = 1; pend_addr = int'(ray_sram_rd_addr); end
      if (!arst_n) begin
         m_state = 0; m_col = 0; m_ray = 0; m_issued = 0; prev_rd = 0;
         chk("reset_outputs", {busy, done, ray_sram_rd, ray_stream_write, result_stream_read, res_sram_wr}, 0);
      end else begin
         ew  = ray_stream_full_n && (m_ray < m_issued - int'(prev_rd));
         er  = (m_state == 1) && (m_issued < m_n) && (m_issued - m_ray - int'(ew) < DEPTH);
         err = (m_state == 1) && result_stream_empty_n && (m_col < m_n);
         chk("busy", busy, m_state != 0);
         chk("done", done, m_state == 2);
         chk("ray_write", ray_stream_write, ew);
         chk("ray_rd", ray_sram_rd, er);
         chk("res_read", result_stream_read, err);
         chk("res_wr", res_sram_wr, err);
         if (ew && ray_stream_write) chk("ray_din", ray_stream_din, ray_val(m_ray));
         if (er && ray_sram_rd) chk("rd_addr", ray_sram_rd_addr, m_issued);
         if (err && res_sram_wr && rq.size() > 0) begin
            chk("res_addr", res_sram_wr_addr, m_col);
            chk("res_din", res_sram_wr_din, res_val(rq[0].id));
         end
         if (ray_stream_write) begin
            w_count++;
            if (w_first < 0) w_first = cyc;
            w_last = cyc;
         end
         if (ray_sram_rd || ray_stream_write || result_stream_read) act++;
         if (res_sram_wr) begin r_count++; res_mem[res_sram_wr_addr[5:0]] = res_sram_wr_din; end
         if (result_stream_read && rq.size() > 0) void'(rq.pop_front());
         if (ew) begin
            if (lb) rq.push_back('{m_ray, cyc + 5});
            m_ray++;
         end
         m_issued += int'(er);
         prev_rd = er;
         if (m_state == 0 && start) begin
            m_state = 1; m_n = int'(num_rays); m_col = 0; m_ray = 0; m_issued = 0; prev_rd = 0;
            w_count = 0; w_first = -1; w_last = -1; r_count = 0; act = 0;
         end else if (m_state == 1) begin
            if (m_col == m_n) m_state = 2;
            m_col += int'(err);
         end else if (m_state == 2) m_state = 0;
      end
   end

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic kick(int n, output int s);
      @(posedge clk);
      #1;
      start = 1;
      num_rays = CNTW'(n);
      s = cyc;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done) begin dc = cyc; break; end
      end
      chk("done_seen", dc >= 0, 1);
   endtask

   task automatic chk_idle_outputs(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd"}, ray_sram_rd, 0);
      chk({tag, "_write"}, ray_stream_write, 0);
      chk({tag, "_read"}, result_stream_read, 0);
      chk({tag, "_res_wr"}, res_sram_wr, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s, dc;
      arst_n = 0;
      cycles(3);
      chk_idle_outputs("rst");
      arst_n = 1;
      cycles(2);

      // 8 rays, free-flowing stream, results looped back after 5 cycles
      lb = 1; fmode = 0;
      kick(8, s);
      wait_done(dc);
      chk("t1_done_cycle", dc, s + 17);
      chk("t1_rays", w_count, 8);
      chk("t1_first_write", w_first, s + 3);
      chk("t1_span", w_last - w_first, 7);
      chk("t1_results", r_count, 8);
      chk("t1_res0", res_mem[0], res_val(0));
      chk("t1_res7", res_mem[7], res_val(7));
      @(negedge clk);
      chk("t1_busy_after", busy, 0);
      cycles(3);

      // 4 rays under alternating back-pressure
      fmode = 1;
      kick(4, s);
      wait_done(dc);
      chk("t2_rays", w_count, 4);
      chk("t2_results", r_count, 4);
      chk("t2_res3", res_mem[3], res_val(3));
      fmode = 0;
      cycles(3);

      // empty job
      lb = 0;
      kick(0, s);
      wait_done(dc);
      chk("t3_done_cycle", dc, s + 2);
      chk("t3_activity", act, 0);
      cycles(3);

      // results arrive out of order, one extra left in the FIFO
      kick(3, s);
      cycles(12);
      chk("t4_rays", w_count, 3);
      rq.push_back('{2, 0});
      rq.push_back('{0, 0});
      rq.push_back('{1, 0});
      rq.push_back('{3, 0});
      wait_done(dc);
      cycles(4);
      chk("t4_addr0", res_mem[0], res_val(2));
      chk("t4_addr1", res_mem[1], res_val(0));
      chk("t4_addr2", res_mem[2], res_val(1));
      chk("t4_left", rq.size(), 1);
      chk("t4_empty_n", result_stream_empty_n, 1);
      rq.delete();
      cycles(2);

      // start mid-job with a different count is ignored
      lb = 1;
      kick(6, s);
      cycles(3);
      start = 1;
      num_rays = CNTW'(99);
      cycles(1);
      start = 0;
      wait_done(dc);
      chk("t5_done_cycle", dc, s + 15);
      chk("t5_rays", w_count, 6);
      chk("t5_results", r_count, 6);
      chk("t5_res5", res_mem[5], res_val(5));
      cycles(3);

      // reset mid-job, then a fresh job
      kick(10, s);
      for (int k = 0; k < 50 && w_count < 3; k++) @(negedge clk);
      chk("t6_partial", w_count >= 3 && w_count < 10, 1);
      @(posedge clk);
      #1;
      arst_n = 0;
      rq.delete();
      #1;
      chk_idle_outputs("t6_rst");
      cycles(2);
      arst_n = 1;
      cycles(1);
      kick(2, s);
      wait_done(dc);
      chk("t6_done_cycle", dc, s + 11);
      chk("t6_rays", w_count, 2);
      chk("t6_results", r_count, 2);
      chk("t6_res1", res_mem[1], res_val(1));
      cycles(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
